bubble_sort_ctrl: RTL

Multi-pass sequencer for the 4-lane one-pass bubble stage (three chained swappers; one pass moves the largest value to lane 4).
- Accepts a 4-word vector on a valid/ready input.
- Runs the stage for 3 passes, feeding each pass result back as the next pass input.
- Returns the ascending-sorted vector on a valid/ready output.
- Sits between the producer and the stage; owns the stage enable and the stage inputs.

---
 rtl/bubble_sort_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bubble_sort_ctrl.sv
// rtl/bubble_sort_ctrl.sv - multi-pass sequencer driving a 4-lane one-pass bubble stage
// Optional SORT_EARLY_EXIT_EN: finish as soon as a pass makes no swap, flagged on early_exit.
module bubble_sort_ctrl #(
  parameter int width     = 8,
  parameter int STAGE_LAT = 3,
  parameter int NPASS     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data1,
  input  logic [width-1:0] in_data2,
  input  logic [width-1:0] in_data3,
  input  logic [width-1:0] in_data4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data1,
  output logic [width-1:0] out_data2,
  output logic [width-1:0] out_data3,
  output logic [width-1:0] out_data4,
  output logic             busy,
  output logic [1:0]       pass_cnt,
`ifdef SORT_EARLY_EXIT_EN
  output logic             early_exit,
`endif
  output logic             stage_en,
  output logic [width-1:0] stage_in1,
  output logic [width-1:0] stage_in2,
  output logic [width-1:0] stage_in3,
  output logic [width-1:0] stage_in4,
  input  logic [width-1:0] stage_out1,
  input  logic [width-1:0] stage_out2,
  input  logic [width-1:0] stage_out3,
  input  logic [width-1:0] stage_out4
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] CAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] LAT_LAST  = 4'(STAGE_LAT - 1);
  localparam logic [1:0] PASS_LAST = 2'(NPASS - 1);

  logic [1:0]       state;
  logic [3:0]       lat_cnt;
  logic [width-1:0] w1, w2, w3, w4;
  logic             no_swap;

`ifdef SORT_EARLY_EXIT_EN
  assign no_swap = (stage_out1 == w1) && (stage_out2 == w2) &&
                   (stage_out3 == w3) && (stage_out4 == w4);
`else
  assign no_swap = 1'b0;
`endif

  // Work registers feed the stage continuously and double as the result.
  assign stage_in1 = w1;
  assign stage_in2 = w2;
  assign stage_in3 = w3;
  assign stage_in4 = w4;
  assign out_data1 = w1;
  assign out_data2 = w2;
  assign out_data3 = w3;
  assign out_data4 = w4;

  assign in_ready  = (state == IDLE);
  assign stage_en  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      pass_cnt <= '0;
      w1       <= '0;
      w2       <= '0;
      w3       <= '0;
      w4       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w1       <= in_data1;
            w2       <= in_data2;
            w3       <= in_data3;
            w4       <= in_data4;
            pass_cnt <= '0;
            lat_cnt  <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_cnt == LAT_LAST) state <= CAP;
        end
        CAP: begin
          w1 <= stage_out1;
          w2 <= stage_out2;
          w3 <= stage_out3;
          w4 <= stage_out4;
          if (pass_cnt == PASS_LAST || no_swap) begin
            state <= DONE;
          end else begin
            pass_cnt <= pass_cnt + 2'd1;
            lat_cnt  <= '0;
            state    <= RUN;
          end
        end
        default: begin
          // Handshake cycle returns to IDLE; in_ready rises only afterwards.
          if (out_ready) begin
            pass_cnt <= '0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef SORT_EARLY_EXIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) early_exit <= 1'b0;
    else if (state == IDLE) early_exit <= 1'b0;
    else if (state == CAP && no_swap) early_exit <= 1'b1;
  end
`endif

endmodule
